vec_mul_sequencer: RTL and testbench

//   Time-multiplexes one external combinational 8x8->16 element multiplier across
//   an N-element vector pair. Captures both vectors on start, issues one element

---
 rtl/vec_mul_sequencer.sv | 139 +++++++++++++
 tb/tb_vec_mul_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vec_mul_sequencer.sv
// vec_mul_sequencer: time-multiplexes one external combinational multiplier
// across an N_ELEM-element vector pair, buffering the element products and
// accumulating their dot product. One job takes N_ELEM+2 cycles.
module vec_mul_sequencer #(
    parameter  int unsigned N_ELEM = 4,
    parameter  int unsigned DW     = 8,
    localparam int unsigned PW     = 2 * DW,
    localparam int unsigned ACC_W  = 2 * DW + $clog2(N_ELEM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [N_ELEM*DW-1:0]   vec_a,
    input  logic [N_ELEM*DW-1:0]   vec_b,
    output logic [DW-1:0]          mul_a,
    output logic [DW-1:0]          mul_b,
    input  logic [PW-1:0]          mul_p,
    output logic                   busy,
    output logic                   done,
    output logic [N_ELEM*PW-1:0]   prod_vec,
    output logic [ACC_W-1:0]       dot
);

    localparam int unsigned IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned VW = N_ELEM * DW;
    localparam int unsigned BW = N_ELEM * PW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic [VW-1:0]     r_cap_a,    w_cap_a_nxt;
    logic [VW-1:0]     r_cap_b,    w_cap_b_nxt;
    logic [IW-1:0]     r_idx,      w_idx_nxt;
    logic [ACC_W-1:0]  r_acc,      w_acc_nxt;
    logic [BW-1:0]     r_pbuf,     w_pbuf_nxt;
    logic [DW-1:0]     r_mul_a,    w_mul_a_nxt;
    logic [DW-1:0]     r_mul_b,    w_mul_b_nxt;
    logic [BW-1:0]     r_prod_vec, w_prod_nxt;
    logic [ACC_W-1:0]  r_dot,      w_dot_nxt;
    logic              r_busy;
    logic              r_done;
    logic [ACC_W-1:0]  w_sum;

    // State, capture, datapath and output registers; async clear of everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cap_a    <= '0;
            r_cap_b    <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_pbuf     <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_prod_vec <= '0;
            r_dot      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cap_a    <= w_cap_a_nxt;
            r_cap_b    <= w_cap_b_nxt;
            r_idx      <= w_idx_nxt;
            r_acc      <= w_acc_nxt;
            r_pbuf     <= w_pbuf_nxt;
            r_mul_a    <= w_mul_a_nxt;
            r_mul_b    <= w_mul_b_nxt;
            r_prod_vec <= w_prod_nxt;
            r_dot      <= w_dot_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state and next-register values; operands are pre-loaded one cycle
    // ahead so the registered mul_a/mul_b carry element idx during each RUN cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cap_a_nxt = r_cap_a;
        w_cap_b_nxt = r_cap_b;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_pbuf_nxt  = r_pbuf;
        w_mul_a_nxt = '0;
        w_mul_b_nxt = '0;
        w_prod_nxt  = r_prod_vec;
        w_dot_nxt   = r_dot;
        w_sum       = r_acc + ACC_W'(mul_p);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_cap_a_nxt = vec_a;
                    w_cap_b_nxt = vec_b;
                    w_idx_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_mul_a_nxt = vec_a[DW-1:0];
                    w_mul_b_nxt = vec_b[DW-1:0];
                end
            end
            S_RUN: begin
                w_pbuf_nxt[r_idx*PW +: PW] = mul_p;
                w_acc_nxt = w_sum;
                w_idx_nxt = r_idx + IW'(1);
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx == IW'(N_ELEM - 1)) begin
                    // Publish on the edge that enters DONE, including this last product
                    w_state_nxt = S_DONE;
                    w_prod_nxt  = w_pbuf_nxt;
                    w_dot_nxt   = w_sum;
                end else begin
                    w_mul_a_nxt = r_cap_a[w_idx_nxt*DW +: DW];
                    w_mul_b_nxt = r_cap_b[w_idx_nxt*DW +: DW];
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign prod_vec = r_prod_vec;
    assign dot      = r_dot;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Testbench for vec_mul_sequencer: directed and random jobs checked against
// an arithmetic reference model of products and dot product.
module tb_vec_mul_sequencer;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned ACC_W = 2 * DW + $clog2(N);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [N*DW-1:0]    vec_a;
    logic [N*DW-1:0]    vec_b;
    logic [DW-1:0]      mul_a;
    logic [DW-1:0]      mul_b;
    logic [PW-1:0]      mul_p;
    logic               busy;
    logic               done;
    logic [N*PW-1:0]    prod_vec;
    logic [ACC_W-1:0]   dot;

    int n_assert = 0;
    int n_fail   = 0;

    // Last published results expected on prod_vec/dot
    logic [N*PW-1:0]    exp_pv;
    logic [ACC_W-1:0]   exp_dot;

    vec_mul_sequencer #(.N_ELEM(N), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .vec_a    (vec_a),
        .vec_b    (vec_b),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .busy     (busy),
        .done     (done),
        .prod_vec (prod_vec),
        .dot      (dot)
    );

    // Shared combinational multiplier
    assign mul_p = PW'(mul_a) * PW'(mul_b);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one job from an IDLE cycle. abort_cyc: cycle in which abort is high
    // (0 = together with start, -1 = never). hold keeps start high afterwards.
    task automatic do_job(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                          input int abort_cyc, input bit hold);
        logic [N*PW-1:0]  pv;
        logic [ACC_W-1:0] d;
        logic [DW-1:0]    ea;
        logic [DW-1:0]    eb;
        int unsigned      p;
        bit               aborted;
        aborted = 1'b0;
        pv = '0;
        d  = '0;
        for (int i = 0; i < N; i++) begin
            p = int'(a[i*DW +: DW]) * int'(b[i*DW +: DW]);
            pv[i*PW +: PW] = PW'(p);
            d = d + ACC_W'(p);
        end
        start = 1'b1;
        vec_a = a;
        vec_b = b;
        abort = (abort_cyc == 0);
        @(posedge clk); #1;
        start = hold;
        abort = 1'b0;
        vec_a = $urandom;
        vec_b = $urandom;
        for (int c = 1; c <= N + 1; c++) begin
            chk("busy_run", 64'(busy), 64'(1));
            chk("done_pulse", 64'(done), 64'(c == N + 1));
            ea = (c <= N) ? a[(c-1)*DW +: DW] : '0;
            eb = (c <= N) ? b[(c-1)*DW +: DW] : '0;
            chk("mul_a_run", 64'(mul_a), 64'(ea));
            chk("mul_b_run", 64'(mul_b), 64'(eb));
            if (c == N + 1) begin
                chk("prod_vec_done", 64'(prod_vec), 64'(pv));
                chk("dot_done", 64'(dot), 64'(d));
            end
            abort = (c == abort_cyc);
            @(posedge clk); #1;
            abort = 1'b0;
            if (c == abort_cyc && c <= N) begin
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            exp_pv  = pv;
            exp_dot = d;
        end
        chk("busy_idle", 64'(busy), 64'(0));
        chk("done_idle", 64'(done), 64'(0));
        chk("mul_a_idle", 64'(mul_a), 64'(0));
        chk("prod_vec_hold", 64'(prod_vec), 64'(exp_pv));
        chk("dot_hold", 64'(dot), 64'(exp_dot));
        if (!hold) start = 1'b0;
    endtask

    initial begin
        start   = 1'b0;
        abort   = 1'b0;
        vec_a   = '0;
        vec_b   = '0;
        exp_pv  = '0;
        exp_dot = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Reset values before any clock edge
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_mul_a", 64'(mul_a), 64'(0));
        chk("rst_mul_b", 64'(mul_b), 64'(0));
        chk("rst_prod_vec", 64'(prod_vec), 64'(0));
        chk("rst_dot", 64'(dot), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic job with known values
        do_job(32'h0403_0201, 32'h0807_0605, -1, 1'b0);
        chk("basic_prod_vec", 64'(prod_vec), 64'h0020_0015_000C_0005);
        chk("basic_dot", 64'(dot), 64'(70));

        // Maximum operands: no wrap in the accumulator
        do_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        chk("max_dot", 64'(dot), 64'(260100));

        // start held across two back-to-back jobs, inputs scrambled during RUN
        do_job(32'($urandom), 32'($urandom), -1, 1'b1);
        do_job(32'($urandom), 32'($urandom), -1, 1'b0);

        // abort in the 2nd RUN cycle: no done, previous results retained
        do_job(32'($urandom), 32'($urandom), 2, 1'b0);
        // abort in the last RUN cycle
        do_job(32'($urandom), 32'($urandom), N, 1'b0);
        // abort during DONE is ignored
        do_job(32'($urandom), 32'($urandom), N + 1, 1'b0);
        // start and abort together in IDLE: start wins
        do_job(32'($urandom), 32'($urandom), 0, 1'b0);

        // Async reset mid-RUN clears outputs immediately
        start = 1'b1;
        vec_a = 32'($urandom);
        vec_b = 32'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_mul_a", 64'(mul_a), 64'(0));
        chk("midrst_mul_b", 64'(mul_b), 64'(0));
        chk("midrst_prod_vec", 64'(prod_vec), 64'(0));
        chk("midrst_dot", 64'(dot), 64'(0));
        exp_pv  = '0;
        exp_dot = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_busy", 64'(busy), 64'(0));
        chk("postrst_done", 64'(done), 64'(0));
        do_job(32'($urandom), 32'($urandom), -1, 1'b0);

        // Random jobs with occasional idle gaps
        for (int j = 0; j < 8; j++) begin
            do_job(32'($urandom), 32'($urandom), -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
